// File: rtl/nts_tx_defs_pkg.sv
// Shared definitions for the NTS transmit buffer: state encodings, MAC widths
// and the legality test for the final-word byte mask.
package nts_tx_defs;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned VALID_W    = 8;
    localparam int unsigned ADDR_W_DEF = 7;

    localparam logic [VALID_W-1:0] VALID_FULL = 8'hFF;
    localparam logic [VALID_W-1:0] VALID_NONE = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_LOADED = 3'd2,
        ST_START  = 3'd3,
        ST_SEND   = 3'd4
    } tx_state_t;

    // Legal masks are contiguous from bit 0: 01,03,07,0F,1F,3F,7F,FF.
    function automatic logic is_legal_mask(input logic [VALID_W-1:0] m);
        return (m != VALID_NONE) && ((m & VALID_W'(m + 1'b1)) == VALID_NONE);
    endfunction

endpackage

// File: rtl/nts_transmitter_if.sv
// Engine-side write/control and MAC TX signals of the NTS transmitter.
interface nts_transmitter_if
    import nts_tx_defs::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF
) ();

    logic                  i_write_en;
    logic [DATA_W-1:0]     i_write_data;
    logic                  i_write_last;
    logic [VALID_W-1:0]    i_write_last_valid;
    logic                  i_transmit;
    logic                  i_discard;
    logic                  o_ready;
    logic                  o_busy;
    logic [ADDR_WIDTH-1:0] o_word_count;
    logic                  o_error;
    logic                  o_tx_done;
    logic                  o_mac_tx_start;
    logic                  i_mac_tx_ack;
    logic [VALID_W-1:0]    o_mac_tx_data_valid;
    logic [DATA_W-1:0]     o_mac_tx_data;

    modport slave (
        input  i_write_en, i_write_data, i_write_last, i_write_last_valid,
        input  i_transmit, i_discard, i_mac_tx_ack,
        output o_ready, o_busy, o_word_count, o_error, o_tx_done,
        output o_mac_tx_start, o_mac_tx_data_valid, o_mac_tx_data
    );

    modport master (
        output i_write_en, i_write_data, i_write_last, i_write_last_valid,
        output i_transmit, i_discard, i_mac_tx_ack,
        input  o_ready, o_busy, o_word_count, o_error, o_tx_done,
        input  o_mac_tx_start, o_mac_tx_data_valid, o_mac_tx_data
    );

endinterface

// File: rtl/nts_tx_ram.sv
// Single-frame buffer: simple dual-port RAM, synchronous write, registered read.
module nts_tx_ram
    import nts_tx_defs::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_W-1:0]     o_rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/nts_transmitter.sv
// NTS transmit buffer: collects one frame from the engine, then streams it to
// the 10G MAC TX port gap-free after the MAC acknowledges word 0.
module nts_transmitter
    import nts_tx_defs::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_areset,
    nts_transmitter_if.slave   bus
);

    localparam logic [ADDR_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    tx_state_t             r_state,     w_state_next;
    logic [ADDR_WIDTH-1:0] r_count,     w_count_next;
    logic [ADDR_WIDTH-1:0] r_last_addr, w_last_addr_next;
    logic [ADDR_WIDTH-1:0] r_rd_addr,   w_rd_addr_next;
    logic [VALID_W-1:0]    r_mask,      w_mask_next;
    logic                  r_error,     w_error_next;
    logic                  r_ready,     w_ready_next;
    logic                  r_busy,      w_busy_next;
    logic                  r_tx_done,   w_tx_done_next;
    logic                  r_mac_start, w_mac_start_next;
    logic [VALID_W-1:0]    r_mac_valid, w_mac_valid_next;
    logic [DATA_W-1:0]     r_mac_data,  w_mac_data_next;
    logic                  w_wr_en;
    logic [DATA_W-1:0]     w_rd_data;

    // Read address is the next-state pointer, so the RAM output always holds
    // the word at r_rd_addr: one word ahead of what the MAC currently sees.
    nts_tx_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_count),
        .i_wr_data (bus.i_write_data),
        .i_rd_addr (w_rd_addr_next),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            r_state     <= ST_IDLE;
            r_count     <= ADDR_ZERO;
            r_last_addr <= ADDR_ZERO;
            r_rd_addr   <= ADDR_ZERO;
            r_mask      <= VALID_NONE;
            r_error     <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_tx_done   <= 1'b0;
            r_mac_start <= 1'b0;
            r_mac_valid <= VALID_NONE;
            r_mac_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_last_addr <= w_last_addr_next;
            r_rd_addr   <= w_rd_addr_next;
            r_mask      <= w_mask_next;
            r_error     <= w_error_next;
            r_ready     <= w_ready_next;
            r_busy      <= w_busy_next;
            r_tx_done   <= w_tx_done_next;
            r_mac_start <= w_mac_start_next;
            r_mac_valid <= w_mac_valid_next;
            r_mac_data  <= w_mac_data_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_last_addr_next = r_last_addr;
        w_rd_addr_next   = r_rd_addr;
        w_mask_next      = r_mask;
        w_error_next     = r_error;
        w_tx_done_next   = 1'b0;
        w_mac_start_next = r_mac_start;
        w_mac_valid_next = r_mac_valid;
        w_mac_data_next  = r_mac_data;
        w_wr_en          = 1'b0;

        unique case (r_state)
            ST_IDLE, ST_WRITE: begin
                w_rd_addr_next = ADDR_ZERO;
                if (bus.i_discard) begin
                    w_state_next = ST_IDLE;
                    w_count_next = ADDR_ZERO;
                    w_error_next = 1'b0;
                end else if (bus.i_write_en) begin
                    if (r_count == COUNT_MAX && !bus.i_write_last) begin
                        w_error_next = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                        // A last word at the top address fills the buffer; count saturates.
                        if (r_count != COUNT_MAX) begin
                            w_count_next = ADDR_WIDTH'(r_count + 1'b1);
                        end
                        if (bus.i_write_last) begin
                            w_last_addr_next = r_count;
                            w_mask_next      = bus.i_write_last_valid;
                            w_state_next     = ST_LOADED;
                            if (!is_legal_mask(bus.i_write_last_valid)) begin
                                w_error_next = 1'b1;
                            end
                        end else begin
                            w_state_next = ST_WRITE;
                        end
                    end
                end
            end

            ST_LOADED: begin
                w_rd_addr_next = ADDR_ZERO;
                if (bus.i_discard) begin
                    w_state_next = ST_IDLE;
                    w_count_next = ADDR_ZERO;
                    w_error_next = 1'b0;
                end else if (bus.i_transmit && !r_error) begin
                    w_state_next = ST_START;
                end
            end

            ST_START: begin
                if (!r_mac_start) begin
                    // Word 0 was prefetched during the transmit cycle.
                    w_mac_start_next = 1'b1;
                    w_mac_data_next  = w_rd_data;
                    w_mac_valid_next = (r_last_addr == ADDR_ZERO) ? r_mask : VALID_FULL;
                    w_rd_addr_next   = ADDR_ONE;
                end else if (bus.i_mac_tx_ack) begin
                    w_mac_start_next = 1'b0;
                    if (r_last_addr == ADDR_ZERO) begin
                        w_state_next     = ST_IDLE;
                        w_count_next     = ADDR_ZERO;
                        w_rd_addr_next   = ADDR_ZERO;
                        w_tx_done_next   = 1'b1;
                        w_mac_valid_next = VALID_NONE;
                        w_mac_data_next  = '0;
                    end else begin
                        w_state_next     = ST_SEND;
                        w_mac_data_next  = w_rd_data;
                        w_mac_valid_next = (r_rd_addr == r_last_addr) ? r_mask : VALID_FULL;
                        w_rd_addr_next   = ADDR_WIDTH'(r_rd_addr + 1'b1);
                    end
                end
            end

            ST_SEND: begin
                // r_rd_addr is one past the word on the MAC bus.
                if (r_rd_addr == ADDR_WIDTH'(r_last_addr + 1'b1)) begin
                    w_state_next     = ST_IDLE;
                    w_count_next     = ADDR_ZERO;
                    w_rd_addr_next   = ADDR_ZERO;
                    w_tx_done_next   = 1'b1;
                    w_mac_valid_next = VALID_NONE;
                    w_mac_data_next  = '0;
                end else begin
                    w_mac_data_next  = w_rd_data;
                    w_mac_valid_next = (r_rd_addr == r_last_addr) ? r_mask : VALID_FULL;
                    w_rd_addr_next   = ADDR_WIDTH'(r_rd_addr + 1'b1);
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_ready_next = (w_state_next == ST_IDLE);
        w_busy_next  = (w_state_next == ST_LOADED) || (w_state_next == ST_START) ||
                       (w_state_next == ST_SEND);
    end

    assign bus.o_ready             = r_ready;
    assign bus.o_busy              = r_busy;
    assign bus.o_word_count        = r_count;
    assign bus.o_error             = r_error;
    assign bus.o_tx_done           = r_tx_done;
    assign bus.o_mac_tx_start      = r_mac_start;
    assign bus.o_mac_tx_data_valid = r_mac_valid;
    assign bus.o_mac_tx_data       = r_mac_data;

endmodule

// File: tb/tb_nts_transmitter.sv
// Directed bench for nts_transmitter with a scoreboard of expected MAC words.
module tb_nts_transmitter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   done_cnt;
    logic [71:0] sb[$];
    logic [63:0] frame[$];

    nts_transmitter_if #(.ADDR_WIDTH(7)) bus ();

    nts_transmitter #(.ADDR_WIDTH(7)) dut (
        .i_clk    (clk),
        .i_areset (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input int n, input logic [7:0] mask);
        logic [63:0] d;
        frame.delete();
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            frame.push_back(d);
            bus.i_write_en         = 1'b1;
            bus.i_write_data       = d;
            bus.i_write_last       = (i == n - 1);
            bus.i_write_last_valid = mask;
            tick();
        end
        bus.i_write_en   = 1'b0;
        bus.i_write_last = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] mask);
        for (int i = 0; i < frame.size(); i++) begin
            sb.push_back({frame[i], (i == frame.size() - 1) ? mask : 8'hFF});
        end
    endtask

    task automatic do_transmit(input string tag);
        bus.i_transmit = 1'b1;
        tick();
        bus.i_transmit = 1'b0;
        chk({tag, "_start_t1"}, 72'(bus.o_mac_tx_start), 72'(0));
        tick();
        chk({tag, "_start_t2"}, 72'(bus.o_mac_tx_start), 72'(1));
    endtask

    task automatic ack_after(input string tag, input int waits);
        repeat (waits) tick();
        chk({tag, "_start_held"}, 72'(bus.o_mac_tx_start), 72'(1));
        bus.i_mac_tx_ack = 1'b1;
        tick();
        bus.i_mac_tx_ack = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (!bus.o_tx_done && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_done_latency"}, 72'(n), 72'(exp_cycles));
    endtask

    // Scoreboard: a word is consumed when the MAC takes it (ack during start).
    always @(negedge clk) begin
        logic [71:0] exp;
        if (!rst) begin
            if (bus.o_mac_tx_data_valid != 8'h00 && (!bus.o_mac_tx_start || bus.i_mac_tx_ack)) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 'x;
                chk("mac_word", {bus.o_mac_tx_data, bus.o_mac_tx_data_valid}, exp);
            end
            if (bus.o_tx_done) begin
                done_cnt++;
                chk("done_sb_empty", 72'(sb.size()), 72'(0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        rst                    = 1'b1;
        bus.i_write_en         = 1'b0;
        bus.i_write_data       = '0;
        bus.i_write_last       = 1'b0;
        bus.i_write_last_valid = '0;
        bus.i_transmit         = 1'b0;
        bus.i_discard          = 1'b0;
        bus.i_mac_tx_ack       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", 72'(bus.o_ready), 72'(1));
        chk("rst_outs", {bus.o_busy, bus.o_error, bus.o_tx_done, bus.o_mac_tx_start,
                         bus.o_mac_tx_data_valid, bus.o_word_count}, 72'(0));
        chk("rst_data", 72'(bus.o_mac_tx_data), 72'(0));

        // 29-word frame, final mask 3F, ack after 3 cycles
        write_frame(29, 8'h3F);
        chk("f29_count", 72'(bus.o_word_count), 72'(29));
        chk("f29_busy_ready", {bus.o_busy, bus.o_ready}, 72'(2'b10));
        push_frame(8'h3F);
        d0 = done_cnt;
        do_transmit("f29");
        chk("f29_word0", {bus.o_mac_tx_data, bus.o_mac_tx_data_valid}, {frame[0], 8'hFF});
        ack_after("f29", 3);
        wait_done("f29", 28);
        tick();
        chk("f29_done_once", 72'(done_cnt), 72'(d0 + 1));
        chk("f29_after", {bus.o_ready, bus.o_tx_done, bus.o_mac_tx_data_valid, bus.o_word_count},
            72'({1'b1, 1'b0, 8'h00, 7'd0}));

        // single word, mask 01
        write_frame(1, 8'h01);
        push_frame(8'h01);
        d0 = done_cnt;
        do_transmit("one");
        chk("one_word0", {bus.o_mac_tx_data, bus.o_mac_tx_data_valid}, {frame[0], 8'h01});
        bus.i_mac_tx_ack = 1'b1;
        tick();
        bus.i_mac_tx_ack = 1'b0;
        chk("one_done", {bus.o_tx_done, bus.o_ready, bus.o_mac_tx_start, bus.o_mac_tx_data_valid},
            72'({1'b1, 1'b1, 1'b0, 8'h00}));
        tick();
        chk("one_done_once", 72'(done_cnt), 72'(d0 + 1));

        // overflow: 128 words without last
        for (int i = 0; i < 128; i++) begin
            bus.i_write_en   = 1'b1;
            bus.i_write_data = {$urandom, $urandom};
            bus.i_write_last = 1'b0;
            tick();
        end
        bus.i_write_en = 1'b0;
        chk("ovf_error", 72'(bus.o_error), 72'(1));
        chk("ovf_count", 72'(bus.o_word_count), 72'(127));
        chk("ovf_ready", 72'(bus.o_ready), 72'(0));
        bus.i_discard = 1'b1;
        tick();
        bus.i_discard = 1'b0;
        chk("ovf_discard", {bus.o_error, bus.o_ready, bus.o_word_count}, 72'({1'b0, 1'b1, 7'd0}));

        // illegal last mask 05
        write_frame(2, 8'h05);
        chk("bad_mask_err", {bus.o_error, bus.o_busy}, 72'(2'b11));
        bus.i_transmit = 1'b1;
        tick();
        bus.i_transmit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bad_mask_nostart", 72'(bus.o_mac_tx_start), 72'(0));
        end
        bus.i_discard = 1'b1;
        tick();
        bus.i_discard = 1'b0;
        chk("bad_mask_clear", {bus.o_error, bus.o_ready}, 72'(2'b01));

        // reset during SEND at word 10
        write_frame(20, 8'h0F);
        push_frame(8'h0F);
        do_transmit("rs");
        ack_after("rs", 1);
        repeat (9) tick();
        chk("rs_word10", {bus.o_mac_tx_data, bus.o_mac_tx_data_valid}, {frame[10], 8'hFF});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        d0 = done_cnt;
        chk("rs_outs", {bus.o_mac_tx_start, bus.o_tx_done, bus.o_mac_tx_data_valid, bus.o_busy,
                        bus.o_error, bus.o_word_count}, 72'(0));
        chk("rs_data", 72'(bus.o_mac_tx_data), 72'(0));
        chk("rs_ready", 72'(bus.o_ready), 72'(1));
        repeat (3) tick();
        chk("rs_no_done", 72'(done_cnt), 72'(d0));
        write_frame(5, 8'h7F);
        push_frame(8'h7F);
        do_transmit("rs2");
        ack_after("rs2", 2);
        wait_done("rs2", 4);
        tick();
        chk("rs2_done_once", 72'(done_cnt), 72'(d0 + 1));

        // transmit + discard together, then writes during SEND
        write_frame(3, 8'hFF);
        bus.i_transmit = 1'b1;
        bus.i_discard  = 1'b1;
        tick();
        bus.i_transmit = 1'b0;
        bus.i_discard  = 1'b0;
        tick();
        chk("td_nostart", {bus.o_mac_tx_start, bus.o_busy, bus.o_ready, bus.o_word_count},
            72'({1'b0, 1'b0, 1'b1, 7'd0}));
        write_frame(6, 8'h1F);
        push_frame(8'h1F);
        d0 = done_cnt;
        do_transmit("ws");
        bus.i_write_en         = 1'b1;
        bus.i_write_data       = 64'hDEAD_BEEF_0BAD_F00D;
        bus.i_write_last       = 1'b1;
        bus.i_write_last_valid = 8'hFF;
        ack_after("ws", 1);
        wait_done("ws", 5);
        bus.i_write_en   = 1'b0;
        bus.i_write_last = 1'b0;
        tick();
        chk("ws_done_once", 72'(done_cnt), 72'(d0 + 1));
        chk("ws_after", {bus.o_error, bus.o_ready, bus.o_word_count}, 72'({1'b0, 1'b1, 7'd0}));
        chk("ws_sb_empty", 72'(sb.size()), 72'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
